// File: rtl/ahb_sram_param_if.sv
// ahb_sram_param_if: AHB-Lite slave-side bus bundle for the parametrised SRAM.
interface ahb_sram_param_if;
    logic        HSEL;
    logic        HREADY;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [31:0] HWDATA;
    logic        HREADYOUT;
    logic        HRESP;
    logic [31:0] HRDATA;

    modport master (
        output HSEL, HREADY, HADDR, HTRANS, HWRITE, HSIZE, HWDATA,
        input  HREADYOUT, HRESP, HRDATA
    );
    modport slave (
        input  HSEL, HREADY, HADDR, HTRANS, HWRITE, HSIZE, HWDATA,
        output HREADYOUT, HRESP, HRDATA
    );
endinterface

// File: rtl/ahb_sram_param.sv
// ahb_sram_param: AHB-Lite single-port SRAM slave with byte lanes, read-after-write
// forwarding, programmable wait states and an optional read-only (ERROR on write) mode.
module ahb_sram_param #(
    parameter int MEM_AW      = 13,
    parameter int WAIT_STATES = 0,
    parameter bit READ_ONLY   = 1'b0
) (
    input  logic            HCLK,
    input  logic            HRESETn,
    ahb_sram_param_if.slave bus
);
    typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_ERR1, ST_ERR2} state_t;

    state_t            state_q, state_d;
    logic [1:0]        wait_q, wait_d;
    logic              wr_q, wr_d;
    logic [MEM_AW-1:0] addr_q, addr_d;
    logic [3:0]        mask_q, mask_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [31:0]       mem [2**MEM_AW];

    logic              accept, commit, rd_now;
    logic [MEM_AW-1:0] haddr_w, raddr;
    logic [3:0]        hmask;
    logic [31:0]       rword;

    assign haddr_w       = bus.HADDR[MEM_AW+1:2];
    assign bus.HREADYOUT = (state_q != ST_ERR1) && (wait_q == 2'd0);
    assign bus.HRESP     = (state_q == ST_ERR1) || (state_q == ST_ERR2);
    assign bus.HRDATA    = rdata_q;
    assign accept        = bus.HSEL && bus.HREADY && bus.HTRANS[1] && bus.HREADYOUT;
    assign commit        = !READ_ONLY && state_q == ST_DATA && wr_q && wait_q == 2'd0;
    assign hmask = (bus.HSIZE == 3'd0) ? 4'b0001 << bus.HADDR[1:0] :
                   (bus.HSIZE == 3'd1) ? (bus.HADDR[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    // With no wait states the read happens at acceptance and may need forwarding;
    // otherwise it is taken on the last wait edge, after any earlier write has landed.
    assign rd_now = (WAIT_STATES == 0) ? accept && !bus.HWRITE
                                       : state_q == ST_DATA && !wr_q && wait_q == 2'd1;
    assign raddr  = (WAIT_STATES == 0) ? haddr_w : addr_q;

    always_comb begin
        rword = mem[raddr];
        for (int i = 0; i < 4; i++)
            if (commit && addr_q == raddr && mask_q[i]) rword[8*i +: 8] = bus.HWDATA[8*i +: 8];
    end

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        mask_d  = mask_q;
        rdata_d = rd_now ? rword : rdata_q;
        if (accept && bus.HWRITE && READ_ONLY) begin
            state_d = ST_ERR1;
            wait_d  = 2'd0;
        end else if (accept) begin
            state_d = ST_DATA;
            wait_d  = 2'(WAIT_STATES);
            wr_d    = bus.HWRITE;
            addr_d  = haddr_w;
            mask_d  = hmask;
        end else if (wait_q != 2'd0) begin
            wait_d = wait_q - 2'd1;
        end else begin
            state_d = (state_q == ST_ERR1) ? ST_ERR2 : ST_IDLE;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q <= ST_IDLE;
            wait_q  <= 2'd0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            mask_q  <= 4'd0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            mask_q  <= mask_d;
            rdata_q <= rdata_d;
        end
    end

    // Storage has no reset; a write is gated by the registered state, so reset aborts it.
    always_ff @(posedge HCLK) begin
        for (int i = 0; i < 4; i++)
            if (commit && mask_q[i]) mem[addr_q][8*i +: 8] <= bus.HWDATA[8*i +: 8];
    end
endmodule

// File: tb/tb_ahb_sram_param.sv
// tb_ahb_sram_param: four SRAM slaves (0/2/3 wait states, read-only) on a shared master,
// checked against a byte-lane memory model.
module tb_ahb_sram_param;
    localparam int WS [4] = '{0, 2, 3, 0};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int          sel = 0;
    logic [31:0] haddr = '0, hwdata = '0;
    logic [1:0]  htrans = 2'b00;
    logic        hwrite = 1'b0;
    logic [2:0]  hsize = 3'd2;
    logic        rdy_a [4];
    logic        resp_a [4];
    logic [31:0] rd_a [4];
    logic        hreadyout, hresp;
    logic [31:0] hrdata;
    logic [31:0] mdl [4][1024];
    int          errors = 0, checks = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : gd
        ahb_sram_param_if b ();
        ahb_sram_param #(.MEM_AW(10), .WAIT_STATES(WS[g]), .READ_ONLY(1'(g == 3))) u (
            .HCLK(clk), .HRESETn(rst_n), .bus(b.slave));
        assign b.HSEL   = (sel == g);
        assign b.HREADY = b.HREADYOUT;
        assign b.HADDR  = haddr;
        assign b.HTRANS = htrans;
        assign b.HWRITE = hwrite;
        assign b.HSIZE  = hsize;
        assign b.HWDATA = hwdata;
        assign rdy_a[g]  = b.HREADYOUT;
        assign resp_a[g] = b.HRESP;
        assign rd_a[g]   = b.HRDATA;
    end

    assign hreadyout = rdy_a[sel];
    assign hresp     = resp_a[sel];
    assign hrdata    = rd_a[sel];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference write: an n-byte transfer covers the n-aligned lanes containing the address.
    task automatic mwrite(input int s, input logic [31:0] a, input logic [2:0] sz, input logic [31:0] wd);
        int n, base, idx;
        n    = (sz == 3'd0) ? 1 : (sz == 3'd1) ? 2 : 4;
        base = (int'(a) % 4) / n * n;
        idx  = (int'(a) / 4) % 1024;
        for (int b = 0; b < 4; b++)
            if (b >= base && b < base + n) mdl[s][idx][8*b +: 8] = wd[8*b +: 8];
    endtask

    task automatic xfer(input int s, input logic wr, input logic [31:0] a, input logic [2:0] sz,
                        input logic [31:0] wd, output logic [31:0] rd, output int w, output logic er);
        sel = s; htrans = 2'b10; hwrite = wr; haddr = a; hsize = sz;
        tick();
        htrans = 2'b00; hwdata = wd; w = 0; er = 1'b0;
        while (!hreadyout && w < 8) begin
            er |= hresp;
            w++;
            tick();
        end
        er |= hresp;
        rd = hrdata;
        tick();
    endtask

    task automatic op(input int s, input logic wr, input logic [31:0] a, input logic [2:0] sz,
                      input logic [31:0] wd, output logic [31:0] rd);
        int w;
        logic er;
        xfer(s, wr, a, sz, wd, rd, w, er);
        chk("waits", 32'(w), 32'(WS[s]));
        chk("okay", {31'd0, er}, 32'd0);
        if (wr) mwrite(s, a, sz, wd);
        else chk("rdata", rd, mdl[s][(int'(a) / 4) % 1024]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] rd, a;
        int ts [4];
        int done, issued;
        logic adv;
        tick(); tick();
        for (int s = 0; s < 4; s++) begin
            sel = s;
            #1;
            chk("rst_ready", {31'd0, hreadyout}, 32'd1);
            chk("rst_resp", {31'd0, hresp}, 32'd0);
            chk("rst_rdata", hrdata, 32'd0);
        end
        rst_n = 1'b1;
        tick();

        op(0, 1'b1, 32'h100, 3'd2, 32'hA5A5_1234, rd);
        op(0, 1'b0, 32'h100, 3'd2, 32'h0, rd);
        chk("word_rd", rd, 32'hA5A5_1234);
        op(0, 1'b0, 32'h100 | (32'd5 << 12), 3'd2, 32'h0, rd);
        chk("alias_rd", rd, 32'hA5A5_1234);

        op(0, 1'b1, 32'h200, 3'd2, 32'h1122_3344, rd);
        op(0, 1'b1, 32'h201, 3'd0, 32'h5555_EE55, rd);
        op(0, 1'b1, 32'h202, 3'd1, 32'hBEEF_1111, rd);
        op(0, 1'b0, 32'h200, 3'd2, 32'h0, rd);
        chk("lanes_rd", rd, 32'hBEEF_EE44);

        // Write immediately followed by a read of the same word.
        sel = 0; htrans = 2'b10; hwrite = 1'b1; haddr = 32'h40; hsize = 3'd2;
        tick();
        hwdata = 32'hDEAD_BEEF; hwrite = 1'b0;
        tick();
        htrans = 2'b00;
        chk("fwd_word", hrdata, 32'hDEAD_BEEF);
        mwrite(0, 32'h40, 3'd2, 32'hDEAD_BEEF);
        tick();
        htrans = 2'b10; hwrite = 1'b1; haddr = 32'h43; hsize = 3'd0;
        tick();
        hwdata = 32'h77AA_BBCC; hwrite = 1'b0; haddr = 32'h40; hsize = 3'd2;
        tick();
        htrans = 2'b00;
        chk("fwd_byte", hrdata, 32'h77AD_BEEF);
        mwrite(0, 32'h43, 3'd0, 32'h77AA_BBCC);
        tick();
        op(0, 1'b0, 32'h40, 3'd2, 32'h0, rd);

        for (int s = 0; s < 3; s++) begin
            for (int i = 0; i < 8; i++) op(s, 1'b1, 32'h80 + 32'(4 * i), 3'd2, $urandom, rd);
            for (int i = 0; i < 30; i++) begin
                a = (32'($urandom_range(0, 15)) << 12) | (32'h80 + 32'(4 * $urandom_range(0, 7)))
                    | 32'($urandom_range(0, 3));
                op(s, 1'($urandom_range(0, 1)), a, 3'($urandom_range(0, 3)), $urandom, rd);
            end
        end

        // Pipelined read stream on the two-wait-state slave.
        sel = 1; hwrite = 1'b0; hsize = 3'd2; htrans = 2'b10; haddr = 32'h80;
        done = 0; issued = 1;
        for (int i = 0; i < 4; i++) ts[i] = 0;
        tick();
        haddr = 32'h84; issued = 2;
        for (int c = 1; done < 4 && c < 60; c++) begin
            adv = hreadyout;
            if (adv) begin
                chk("stream_rd", hrdata, mdl[1][32 + done]);
                ts[done] = c;
                done++;
            end
            tick();
            if (adv) begin
                if (issued < 4) begin
                    haddr = 32'h80 + 32'(4 * issued);
                    issued++;
                end else htrans = 2'b00;
            end
        end
        htrans = 2'b00;
        chk("stream_done", 32'(done), 32'd4);
        chk("stream_first", 32'(ts[0]), 32'd3);
        chk("stream_gap1", 32'(ts[1] - ts[0]), 32'd3);
        chk("stream_gap3", 32'(ts[3] - ts[2]), 32'd3);

        // Read-only slave: two-cycle ERROR, then a read accepted during the second cycle.
        sel = 3; htrans = 2'b10; hwrite = 1'b1; haddr = 32'h0; hsize = 3'd2;
        tick();
        htrans = 2'b00; hwdata = 32'hFFFF_FFFF;
        chk("ro_c1_ready", {31'd0, hreadyout}, 32'd0);
        chk("ro_c1_resp", {31'd0, hresp}, 32'd1);
        tick();
        chk("ro_c2_ready", {31'd0, hreadyout}, 32'd1);
        chk("ro_c2_resp", {31'd0, hresp}, 32'd1);
        htrans = 2'b10; hwrite = 1'b0;
        tick();
        htrans = 2'b00;
        chk("ro_rd_ready", {31'd0, hreadyout}, 32'd1);
        chk("ro_rd_resp", {31'd0, hresp}, 32'd0);
        checks++;
        assert (hrdata !== 32'hFFFF_FFFF) else begin
            errors++;
            $error("FAIL ro_unchanged: observed %h expected anything but %h", hrdata, 32'hFFFF_FFFF);
        end
        tick();

        // Reset during a three-wait-state write aborts it.
        op(2, 1'b1, 32'h300, 3'd2, 32'h0BAD_F00D, rd);
        op(2, 1'b0, 32'h300, 3'd2, 32'h0, rd);
        sel = 2; htrans = 2'b10; hwrite = 1'b1; haddr = 32'h300; hsize = 3'd2;
        tick();
        htrans = 2'b00; hwdata = 32'h1234_5678;
        chk("rstw_wait", {31'd0, hreadyout}, 32'd0);
        tick();
        rst_n = 1'b0;
        #1;
        chk("rstw_ready", {31'd0, hreadyout}, 32'd1);
        chk("rstw_resp", {31'd0, hresp}, 32'd0);
        chk("rstw_rdata", hrdata, 32'd0);
        tick(); tick();
        rst_n = 1'b1;
        tick();
        op(2, 1'b0, 32'h300, 3'd2, 32'h0, rd);
        chk("rstw_kept", rd, 32'h0BAD_F00D);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ahb_sram_param.md
# ahb_sram_param

Parametrised AHB-Lite memory slave for the Cortex-M3 system bus, replacing the fixed read-only instruction ROM slave. It provides a single-port on-chip memory of configurable depth with byte/halfword/word writes, read-after-write forwarding, programmable wait states and an optional read-only mode. In read-only mode, writes receive an AHB ERROR response. It sits directly on the AHB-Lite interconnect behind the address decoder's HSEL.

## Interface
- MEM_AW, 13, word-address bits; memory holds 2^MEM_AW 32-bit words (default 32 KB)
- WAIT_STATES, 0, data-phase wait cycles inserted per accepted read/write transfer, legal 0..3
- READ_ONLY, 0, 1 = writes rejected with ERROR, memory never modified by the bus
- HCLK  in  1  bus clock; all state on rising edge
- HRESETn  in  1  asynchronous active-low reset
- HSEL  in  1  slave select from decoder
- HREADY  in  1  bus-wide ready; address phase sampled only when high
- HADDR  in  32  byte address; bits [MEM_AW+1:2] used, upper bits ignored (aliasing)
- HTRANS  in  2  transfer type; NONSEQ/SEQ = active, IDLE/BUSY = no transfer
- HWRITE  in  1  1 = write
- HSIZE  in  3  0 byte, 1 halfword, 2 word; values >2 treated as word
- HWDATA  in  32  write data, data phase
- HREADYOUT  out  1  slave ready
- HRESP  out  1  0 OKAY, 1 ERROR
- HRDATA  out  32  read data, data phase

## Operation
- Transfer accepted on a rising edge with HSEL & HREADY & HTRANS[1]; register word address, write flag and byte-lane mask.
- Lane mask, little-endian: HSIZE 0 → lane HADDR[1:0]; HSIZE 1 → lanes 1:0 if HADDR[1]=0, else 3:2; word → all four lanes. HADDR misalignment is not checked.
- Wait counter:
  - loaded with WAIT_STATES on an accepted OKAY transfer; HREADYOUT=0 while nonzero; decrements each cycle.
  - Data phase lasts WAIT_STATES+1 cycles.
- Write (READ_ONLY=0): HWDATA lanes selected by mask are committed at the final data-phase edge (HREADYOUT=1). Unselected lanes are unchanged.
- Read: HRDATA valid in the final data-phase cycle. It holds the last read value otherwise. It is never driven from an unselected/IDLE cycle's address.
- Read-after-write: a read whose address phase coincides with a preceding write's final data-phase cycle to the same word returns the merged new data. Per-lane forwarding applies: new lanes from HWDATA, old lanes from memory.
- READ_ONLY=1 write: two-cycle ERROR response, no wait states applied.
  - cycle 1: HREADYOUT=0, HRESP=1
  - cycle 2: HREADYOUT=1, HRESP=1
  - Memory unchanged.
  - An address phase presented during cycle 2 is accepted normally.
- IDLE/BUSY/unselected: zero-wait OKAY, no state change.
- Memory array has no reset; contents undefined until written (or preloaded by synthesis init).

## Timing
- Reset values: HREADYOUT=1, HRESP=0, HRDATA=0, wait counter=0, pending write cleared.
- Reset asserted mid-transfer aborts it. A write not yet at its final data-phase edge is not committed.
- Read, WAIT_STATES=0: address cycle N → HRDATA valid, HREADYOUT=1 in N+1.
- Read, WAIT_STATES=k: HREADYOUT=0 in N+1..N+k; data valid, HREADYOUT=1 in N+k+1.
- Write: address N, HWDATA sampled at end of N+k+1. The result is visible to a read with address phase N+k+1 (forwarded) or later.
- Back-to-back pipelined transfers sustain one transfer per WAIT_STATES+1 cycles.
- ERROR response: address N → N+1 (HREADYOUT=0, HRESP=1) → N+2 (HREADYOUT=1, HRESP=1) → OKAY thereafter.

## Test plan
- Reset then word write 0xA5A5_1234 to 0x100, read 0x100 (WAIT_STATES=0) → HRDATA=0xA5A5_1234 one cycle after read address phase, HRESP=0 throughout.
- Byte write 0xEE to 0x101 and halfword write 0xBEEF to 0x102 over word 0x11223344 → read returns 0xBEEF_EE44.
- Back-to-back write 0xDEADBEEF to 0x40 immediately followed by read of 0x40 → read returns 0xDEADBEEF (forwarding); repeat with a byte write 0x77 at 0x43 → 0x77ADBEEF.
- WAIT_STATES=2: read → HREADYOUT low exactly 2 cycles, data in third; pipelined read stream → one transfer per 3 cycles.
- READ_ONLY=1: write 0xFFFF_FFFF to 0x0 → HREADYOUT 0/1 with HRESP 1/1 over two cycles; subsequent read returns original content, HRESP=0.
- Assert HRESETn low during a write's wait state (WAIT_STATES=3) → outputs return to reset values immediately; following read shows word unchanged.
